// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter/receiver pair: FSM states,
// parity mode encodings and the expected-parity helper.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  localparam logic [1:0] PARITY_NONE0 = 2'b00;
  localparam logic [1:0] PARITY_ODD   = 2'b01;
  localparam logic [1:0] PARITY_EVEN  = 2'b10;
  localparam logic [1:0] PARITY_NONE1 = 2'b11;

  function automatic logic parity_en(input logic [1:0] mode);
    return (mode == PARITY_ODD) || (mode == PARITY_EVEN);
  endfunction

  // Parity bit the transmitter appends; 0 when parity is disabled.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
    case (mode)
      PARITY_ODD:  return ~^data;
      PARITY_EVEN: return ^data;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/serial_rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module serial_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx_deser.sv
// Serial receiver: start detect, 8 LSB-first data bits, optional parity, stop check.
// Define SERIAL_RX_SYNC_EN to pass RXD through a 2-flop synchronizer first.
module serial_rx_deser
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_W       = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RXD,
  input  logic [1:0]        PARITY_MODE,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_VALID,
  output logic              PARITY_ERR,
  output logic              FRAME_ERR,
  output logic              BUSY
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BC_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [BC_W-1:0]  BIT_MAX  = BC_W'(DATA_W - 1);

  logic              rxd;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [1:0]        mode;
  logic              par_mis;

`ifdef SERIAL_RX_SYNC_EN
  serial_rx_sync u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (RXD),
    .q   (rxd)
  );
`else
  assign rxd = RXD;
`endif

  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      mode       <= PARITY_NONE0;
      par_mis    <= 1'b0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxd) begin
            mode    <= PARITY_MODE;
            par_mis <= 1'b0;
            bit_cnt <= '0;
            // With one clock per bit the start bit is already mid-bit here.
            if (HALF == '0) begin
              state <= DATA;
              cnt   <= BIT_LAST;
            end else begin
              state <= START;
              cnt   <= HALF;
            end
          end
        end
        START: begin
          if (cnt == CNT_W'(1)) begin
            if (!rxd) begin
              state <= DATA;
              cnt   <= BIT_LAST;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            cnt     <= BIT_LAST;
            shreg   <= {rxd, shreg[DATA_W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_MAX)
              state <= parity_en(mode) ? PARITY : STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PARITY: begin
          if (cnt == '0) begin
            cnt     <= BIT_LAST;
            par_mis <= rxd ^ parity_bit(shreg, mode);
            state   <= STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            DATA_OUT   <= shreg;
            DATA_VALID <= 1'b1;
            PARITY_ERR <= par_mis;
            FRAME_ERR  <= ~rxd;
            // A low stop bit may be a break; wait for the line to return high.
            state      <= rxd ? IDLE : WAIT_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rxd) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx_deser.sv
// Randomized and directed bench for serial_rx_deser at 1 and 4 clocks per bit,
// checked against a frame-level reference model.
module tb_serial_rx_deser;
  import serial_pkg::*;

`ifdef SERIAL_RX_SYNC_EN
  localparam int SYNC_OFF = 2;
`else
  localparam int SYNC_OFF = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd1, rxd4;
  logic [1:0] pm1, pm4;
  logic [7:0] do1, do4;
  logic       v1, v4, pe1, pe4, fe1, fe4, b1, b4;

  always #5 clk = ~clk;

  serial_rx_deser #(.CLKS_PER_BIT(1), .DATA_W(8)) dut1 (
    .CLK(clk), .RST(rst), .RXD(rxd1), .PARITY_MODE(pm1), .DATA_OUT(do1),
    .DATA_VALID(v1), .PARITY_ERR(pe1), .FRAME_ERR(fe1), .BUSY(b1));

  serial_rx_deser #(.CLKS_PER_BIT(4), .DATA_W(8)) dut4 (
    .CLK(clk), .RST(rst), .RXD(rxd4), .PARITY_MODE(pm4), .DATA_OUT(do4),
    .DATA_VALID(v4), .PARITY_ERR(pe4), .FRAME_ERR(fe4), .BUSY(b4));

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         edge_n;
  } ev_t;

  ev_t obs1[$], obs4[$], exp1[$], exp4[$];
  int  edge_cnt = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Record every cycle in which DATA_VALID is high, with the edge that set it.
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (v1) begin
      e.data = do1; e.perr = pe1; e.ferr = fe1; e.edge_n = edge_cnt;
      obs1.push_back(e);
    end
    if (v4) begin
      e.data = do4; e.perr = pe4; e.ferr = fe4; e.edge_n = edge_cnt;
      obs4.push_back(e);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rxd(input int which, input logic b);
    if (which == 1) rxd1 = b; else rxd4 = b;
  endtask

  task automatic set_mode(input int which, input logic [1:0] m);
    if (which == 1) pm1 = m; else pm4 = m;
  endtask

  // Transmit one frame on the chosen line and queue the frame the receiver must report.
  task automatic send_frame(input int which, input logic [7:0] d, input logic [1:0] mode,
                            input bit flip, input bit stop_b, input int brk, input int idle);
    logic bits[$];
    int   cpb, half, s;
    bit   pen;
    logic p;
    ev_t  e;
    cpb  = (which == 1) ? 1 : 4;
    half = cpb / 2;
    s    = 0;
    pen  = (mode == PARITY_ODD) || (mode == PARITY_EVEN);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) begin
      p = (mode == PARITY_ODD) ? ($countones(d) % 2 == 0) : ($countones(d) % 2 == 1);
      bits.push_back(p ^ flip);
    end
    bits.push_back(stop_b);
    for (int i = 0; i < bits.size(); i++) begin
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        if (i == 0 && c == 0) s = edge_cnt + 1;
        if (i == 0) set_mode(which, mode);
        else if (i >= 3) set_mode(which, 2'($urandom_range(0, 3)));
        set_rxd(which, bits[i]);
      end
    end
    e.data   = d;
    e.perr   = pen & flip;
    e.ferr   = ~stop_b;
    e.edge_n = s + half + (bits.size() - 1) * cpb + SYNC_OFF;
    if (which == 1) exp1.push_back(e); else exp4.push_back(e);
    repeat (brk) begin @(negedge clk); set_rxd(which, 1'b0); end
    repeat (idle) begin @(negedge clk); set_rxd(which, 1'b1); end
  endtask

  task automatic compare_q(input int which, input string tag);
    ev_t o[$], e[$];
    repeat (40) @(negedge clk);
    if (which == 1) begin
      o = obs1; e = exp1; obs1.delete(); exp1.delete();
    end else begin
      o = obs4; e = exp4; obs4.delete(); exp4.delete();
    end
    check($sformatf("%s/count", tag), o.size(), e.size());
    for (int i = 0; i < e.size(); i++) begin
      if (i < o.size()) begin
        check($sformatf("%s/data%0d", tag, i), o[i].data, e[i].data);
        check($sformatf("%s/perr%0d", tag, i), o[i].perr, e[i].perr);
        check($sformatf("%s/ferr%0d", tag, i), o[i].ferr, e[i].ferr);
        check($sformatf("%s/edge%0d", tag, i), o[i].edge_n, e[i].edge_n);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cc;
    rst = 1'b1; rxd1 = 1'b1; rxd4 = 1'b1; pm1 = 2'b00; pm4 = 2'b00;
    repeat (2) @(negedge clk);
    check("rst/do1", do1, 8'h00);
    check("rst/v1", v1, 1'b0);
    check("rst/busy1", b1, 1'b0);
    check("rst/do4", do4, 8'h00);
    @(negedge clk) rst = 1'b0;

    // Idle line
    repeat (20) @(negedge clk);
    check("idle/busy1", b1, 1'b0);
    check("idle/busy4", b4, 1'b0);
    check("idle/do1", do1, 8'h00);
    compare_q(1, "idle");

    // Directed frames
    send_frame(1, 8'hA3, PARITY_ODD, 1'b0, 1'b1, 0, 3);
    compare_q(1, "odd_a3");
    send_frame(1, 8'h55, PARITY_EVEN, 1'b1, 1'b1, 0, 3);
    send_frame(1, 8'hC3, PARITY_EVEN, 1'b0, 1'b1, 0, 3);
    compare_q(1, "even");

    // Framing error followed by a break
    send_frame(1, 8'hF0, PARITY_NONE0, 1'b0, 1'b0, 5, 0);
    @(posedge clk); #1;
    check("break/busy", b1, 1'b1);
    @(negedge clk) rxd1 = 1'b1;
    repeat (3 + SYNC_OFF) @(negedge clk);
    check("break/idle", b1, 1'b0);
    compare_q(1, "break");

    // Back-to-back frames with no idle gap
    send_frame(1, 8'h11, PARITY_NONE0, 1'b0, 1'b1, 0, 0);
    send_frame(1, 8'h22, PARITY_ODD, 1'b0, 1'b1, 0, 3);
    compare_q(1, "b2b");

    // Reset after D3 of 0xCC aborts the frame
    cc = 8'hCC;
    @(negedge clk) begin pm1 = PARITY_NONE0; rxd1 = 1'b0; end
    for (int i = 0; i < 4; i++) begin @(negedge clk); rxd1 = cc[i]; end
    @(negedge clk) rst = 1'b1;
    #1;
    check("midrst/do1", do1, 8'h00);
    check("midrst/v1", v1, 1'b0);
    check("midrst/pe1", pe1, 1'b0);
    check("midrst/fe1", fe1, 1'b0);
    check("midrst/busy1", b1, 1'b0);
    @(negedge clk) begin rst = 1'b0; rxd1 = 1'b1; end
    compare_q(1, "midrst");

    // Loopback-style clean frames at both bit rates
    for (int w = 0; w < 2; w++) begin
      int which;
      which = (w == 0) ? 1 : 4;
      send_frame(which, 8'h00, PARITY_ODD, 1'b0, 1'b1, 0, 2);
      send_frame(which, 8'hFF, PARITY_ODD, 1'b0, 1'b1, 0, 2);
      send_frame(which, 8'h00, PARITY_EVEN, 1'b0, 1'b1, 0, 2);
      send_frame(which, 8'hFF, PARITY_EVEN, 1'b0, 1'b1, 0, 2);
      compare_q(which, $sformatf("loop%0d", which));
    end

    // Randomized frames
    for (int w = 0; w < 2; w++) begin
      int which;
      which = (w == 0) ? 1 : 4;
      for (int n = 0; n < 12; n++) begin
        logic [7:0] d;
        logic [1:0] m;
        bit flip, stop_b;
        int brk, idle;
        d      = 8'($urandom);
        m      = 2'($urandom_range(0, 3));
        flip   = ($urandom_range(0, 3) == 0);
        stop_b = ($urandom_range(0, 4) != 0);
        brk    = stop_b ? 0 : $urandom_range(0, 3);
        idle   = stop_b ? $urandom_range(0, 3) : 1 + $urandom_range(0, 3);
        send_frame(which, d, m, flip, stop_b, brk, idle);
      end
      compare_q(which, $sformatf("rand%0d", which));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
